// File: rtl/reset_sequencer_pkg.sv
// Shared types and AXI response codes for the reset sequencer.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWresp,
        StRead,
        StRresp,
        StWait
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/reset_sequencer_single_master.sv
// Single-outstanding AXI4-Lite master: one write or one read per request, all channel
// outputs registered. o_wr_issued / o_rd_issued flag the cycle the address phase completes.
module axi4_lite_single_master #(
    parameter int unsigned C_ADDR_WIDTH = 3,
    parameter int unsigned C_DATA_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      i_req,
    input  logic                      i_we,
    input  logic [C_ADDR_WIDTH-1:0]   i_addr,
    input  logic [C_DATA_WIDTH-1:0]   i_wdata,
    output logic                      o_wr_issued,
    output logic                      o_rd_issued,
    output logic                      o_ack,
    output logic [1:0]                o_resp,
    output logic [C_DATA_WIDTH-1:0]   o_rdata,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);
    localparam int unsigned STRB_W = C_DATA_WIDTH / 8;
    localparam logic [STRB_W-1:0] STRB_LANE0 = STRB_W'(1);

    logic                    r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic [C_ADDR_WIDTH-1:0] r_awaddr, r_araddr;
    logic [C_DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]       r_wstrb;
    logic                    w_aw_pend, w_w_pend, w_b_hs, w_r_hs;

    // AW and W retire independently; the write is issued once neither is still pending.
    assign w_aw_pend   = r_awvalid & ~m_axi_awready;
    assign w_w_pend    = r_wvalid & ~m_axi_wready;
    assign o_wr_issued = (r_awvalid | r_wvalid) & ~w_aw_pend & ~w_w_pend;
    assign o_rd_issued = r_arvalid & m_axi_arready;
    assign w_b_hs      = r_bready & m_axi_bvalid;
    assign w_r_hs      = r_rready & m_axi_rvalid;
    assign o_ack       = w_b_hs | w_r_hs;
    assign o_resp      = w_b_hs ? m_axi_bresp : m_axi_rresp;
    assign o_rdata     = m_axi_rdata;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            if (i_req && i_we) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= i_addr;
                r_wdata   <= i_wdata;
                r_wstrb   <= STRB_LANE0;
            end else begin
                r_awvalid <= w_aw_pend;
                r_wvalid  <= w_w_pend;
            end
            if (o_wr_issued) begin
                r_bready <= 1'b1;
            end else if (w_b_hs) begin
                r_bready <= 1'b0;
            end
            if (i_req && !i_we) begin
                r_arvalid <= 1'b1;
                r_araddr  <= i_addr;
            end else if (o_rd_issued) begin
                r_arvalid <= 1'b0;
            end
            if (o_rd_issued) begin
                r_rready <= 1'b1;
            end else if (w_r_hs) begin
                r_rready <= 1'b0;
            end
        end
    end

    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release/assert over AXI4-Lite: write each output's control register,
// read it back, then wait the programmed delay before the next output.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned C_OUTPUT_COUNT     = 2,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 3,
    parameter int unsigned C_BASE_ADDR        = 0,
    parameter int unsigned C_DELAY_WIDTH      = 16,
    localparam int unsigned IDX_W = (C_OUTPUT_COUNT > 1) ? $clog2(C_OUTPUT_COUNT) : 1
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            start,
    input  logic                            value,
    input  logic [C_DELAY_WIDTH-1:0]        delay,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [IDX_W-1:0]                err_index,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);
    localparam int unsigned STRIDE = C_M_AXI_DATA_WIDTH / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_OUTPUT_COUNT - 1);

    state_e                           r_state, w_state_d;
    logic                             r_value, r_busy, r_done, r_error;
    logic [C_DELAY_WIDTH-1:0]         r_delay, r_cnt, w_cnt_d;
    logic [IDX_W-1:0]                 r_index, r_err_index, w_index_d, w_req_idx;
    logic [IDX_W-1:0]                 w_first_idx, w_next_idx;
    logic                             w_last, w_accept, w_finish, w_abort;
    logic                             w_req, w_we, w_req_value;
    logic                             w_wr_issued, w_rd_issued, w_ack, w_check_ok;
    logic [1:0]                       w_resp;
    logic [C_M_AXI_DATA_WIDTH-1:0]    w_rdata, w_wdata;
    logic [C_M_AXI_ADDR_WIDTH-1:0]    w_addr;
    logic                             w_unused_rdata;

    assign w_first_idx    = value ? '0 : LAST_IDX;
    assign w_next_idx     = r_value ? r_index + IDX_W'(1) : r_index - IDX_W'(1);
    assign w_last         = r_value ? (r_index == LAST_IDX) : (r_index == '0);
    assign w_req_value    = w_accept ? value : r_value;
    assign w_addr         = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR + STRIDE * 32'(w_req_idx));
    assign w_wdata        = {{(C_M_AXI_DATA_WIDTH - 1){1'b0}}, w_req_value};
    assign w_check_ok     = (w_resp == RESP_OKAY) && (w_rdata[0] == r_value);
    assign w_unused_rdata = ^w_rdata[C_M_AXI_DATA_WIDTH-1:1];

    always_comb begin
        w_state_d = r_state;
        w_index_d = r_index;
        w_cnt_d   = r_cnt;
        w_req_idx = r_index;
        w_req     = 1'b0;
        w_we      = 1'b0;
        w_accept  = 1'b0;
        w_finish  = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            StIdle: begin
                // r_done marks the pulse cycle; a start landing there is dropped.
                if (start && !r_done) begin
                    w_accept  = 1'b1;
                    w_req     = 1'b1;
                    w_we      = 1'b1;
                    w_req_idx = w_first_idx;
                    w_index_d = w_first_idx;
                    w_state_d = StWrite;
                end
            end
            StWrite: if (w_wr_issued) w_state_d = StWresp;
            StWresp: begin
                if (w_ack) begin
                    if (w_resp != RESP_OKAY) begin
                        w_abort   = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_req     = 1'b1;
                        w_state_d = StRead;
                    end
                end
            end
            StRead: if (w_rd_issued) w_state_d = StRresp;
            StRresp: begin
                if (w_ack) begin
                    if (!w_check_ok) begin
                        w_abort   = 1'b1;
                        w_state_d = StIdle;
                    end else if (w_last) begin
                        w_finish  = 1'b1;
                        w_state_d = StIdle;
                    end else if (r_delay == '0) begin
                        w_req     = 1'b1;
                        w_we      = 1'b1;
                        w_req_idx = w_next_idx;
                        w_index_d = w_next_idx;
                        w_state_d = StWrite;
                    end else begin
                        w_cnt_d   = r_delay;
                        w_state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (r_cnt == C_DELAY_WIDTH'(1)) begin
                    w_req     = 1'b1;
                    w_we      = 1'b1;
                    w_req_idx = w_next_idx;
                    w_index_d = w_next_idx;
                    w_state_d = StWrite;
                end else begin
                    w_cnt_d = r_cnt - C_DELAY_WIDTH'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= StIdle;
            r_value     <= 1'b0;
            r_delay     <= '0;
            r_cnt       <= '0;
            r_index     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= '0;
        end else begin
            r_state <= w_state_d;
            r_index <= w_index_d;
            r_cnt   <= w_cnt_d;
            r_done  <= w_finish | w_abort;
            // busy stays high through the done cycle.
            if (w_accept) begin
                r_value <= value;
                r_delay <= delay;
                r_error <= 1'b0;
                r_busy  <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
            if (w_abort) begin
                r_error     <= 1'b1;
                r_err_index <= r_index;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign err_index = r_err_index;

    axi4_lite_single_master #(
        .C_ADDR_WIDTH (C_M_AXI_ADDR_WIDTH),
        .C_DATA_WIDTH (C_M_AXI_DATA_WIDTH)
    ) u_master (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .i_req         (w_req),
        .i_we          (w_we),
        .i_addr        (w_addr),
        .i_wdata       (w_wdata),
        .o_wr_issued   (w_wr_issued),
        .o_rd_issued   (w_rd_issued),
        .o_ack         (w_ack),
        .o_resp        (w_resp),
        .o_rdata       (w_rdata),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

endmodule
